seq_divider: RTL and testbench

//   Multi-cycle iterative divider for DIV/DIVU/MOD/MODU. Restoring algorithm, one quotient bit per clock.

---
 rtl/seq_divider.sv | 149 ++++++++++++++
 tb/tb_seq_divider.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Iterative restoring divider for DIV/DIVU/MOD/MODU, one quotient bit per clock.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   start        request a division (accepted only when idle)
//   signed_op    1 = signed DIV/MOD, 0 = unsigned DIVU/MODU (sampled with start)
//   flush        abandon the operation in flight
//   a, b         dividend and divisor (sampled with start)
//   busy         high while iterating
//   valid        one-cycle pulse when q/r/div_by_zero are fresh
//   q, r         quotient and remainder, held until the next result
//   div_by_zero  divisor was zero for the current result
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvsr_q;
  logic             neg_q_q, neg_r_q;
  logic [WIDTH-1:0] q_q, r_q;
  logic             dbz_q;

  logic             accept;
  logic             last_step;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             trial_ge;
  logic [WIDTH-1:0] rem_nx, quo_nx;

  // flush beats start in idle, so nothing is accepted on a flush cycle
  assign accept    = (state_q == StIdle) && start && !flush;
  assign last_step = (state_q == StCalc) && (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    abs_a = (signed_op && a[WIDTH-1]) ? -a : a;
    abs_b = (signed_op && b[WIDTH-1]) ? -b : b;
  end

  // One restoring step. rem < divisor always holds, so the shifted partial remainder
  // fits in WIDTH+1 bits and the restored value fits back in WIDTH bits.
  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    trial    = {1'b0, shifted} - {2'b00, dvsr_q};
    trial_ge = !trial[WIDTH+1];
    rem_nx   = trial_ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_nx   = {quo_q[WIDTH-2:0], trial_ge};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = (b == '0) ? StDone : StCalc;
        end
      end
      StCalc: begin
        if (flush) begin
          state_d = StIdle;
        end else if (last_step) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy  = 1'b0;
    valid = 1'b0;
    unique case (state_q)
      StCalc:  busy  = 1'b1;
      StDone:  valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else if (accept) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= abs_a;
      dvsr_q  <= abs_b;
      neg_q_q <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r_q <= signed_op & a[WIDTH-1];
      dbz_q   <= (b == '0);
      // Zero divisor skips iteration; raw dividend is the remainder, no sign fix-up
      if (b == '0) begin
        q_q <= '1;
        r_q <= a;
      end
    end else if ((state_q == StCalc) && !flush) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      cnt_q <= cnt_q + 1'b1;
      if (last_step) begin
        q_q <= neg_q_q ? -quo_nx : quo_nx;
        r_q <= neg_r_q ? -rem_nx : rem_nx;
      end
    end
  end

  assign q           = q_q;
  assign r           = r_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Randomised scoreboard bench for seq_divider: the driver pushes the expected result of
// every accepted division, an independent monitor pops and compares whenever valid rises.
module tb_seq_divider;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          signed_op = 1'b0;
  logic          flush = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy, valid, div_by_zero;
  logic [W-1:0]  q, r;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  int           edge_cnt = 0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_op   (signed_op),
    .flush       (flush),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .valid       (valid),
    .q           (q),
    .r           (r),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit integer division, truncating toward zero.
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                output logic [W-1:0] mq, output logic [W-1:0] mr,
                                output logic mz);
    longint sx, sy, qq, rr;
    if (y == '0) begin
      mq = '1;
      mr = x;
      mz = 1'b1;
      return;
    end
    sx = s ? {{32{x[W-1]}}, x} : {32'b0, x};
    sy = s ? {{32{y[W-1]}}, y} : {32'b0, y};
    qq = sx / sy;
    rr = sx % sy;
    mq = qq[W-1:0];
    mr = rr[W-1:0];
    mz = 1'b0;
  endfunction

  // Issue a start in the next cycle and return the index of the accepting edge.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                       output int n);
    exp_t e;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_v; signed_op = ts;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = edge_cnt;
    model(ta, tb_v, ts, e.q, e.r, e.dbz);
    e.due = n + ((tb_v == '0) ? 0 : W);
    sb.push_back(e);
  endtask

  // Wait (bounded) for valid, counting busy cycles, then step into idle.
  task automatic finish_op(input logic zero_div);
    int k = 0;
    int nb = 0;
    while (!valid && k < 200) begin
      @(negedge clk);
      if (busy) nb++;
      k++;
    end
    if (k >= 200) begin
      total++;
      bad++;
      $display("FAIL timeout: valid never seen after %0d cycles", k);
      sb.delete();
    end
    chk("busy_cycles", 32'(nb), zero_div ? 32'd0 : 32'(W));
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts);
    int n;
    issue(ta, tb_v, ts, n);
    finish_op(tb_v == '0);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && valid) begin
        total++;
        bad++;
        $display("FAIL busy_and_valid: both high at edge %0d", edge_cnt);
      end
      if (valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got valid=1 want no result at edge %0d", edge_cnt);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("q", q, e.q);
          chk("r", r, e.r);
          chk("dbz", {31'b0, div_by_zero}, {31'b0, e.dbz});
          chk("latency_edge", 32'(edge_cnt), 32'(e.due));
          last_q = e.q;
          last_r = e.r;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [W-1:0] ra, rb;
    logic rs;

    // Reset state
    #23;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_q", q, 32'd0);
    chk("rst_r", r, 32'd0);
    chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run(32'd100, 32'd7, 1'b0);
    run(32'hFFFF_FFF9, 32'd2, 1'b1);
    run(32'd7, 32'hFFFF_FFFE, 1'b1);
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run(32'hFFFF_FFFF, 32'd1, 1'b0);
    run(32'hFFFF_FFF9, 32'd2, 1'b0);
    run(32'd5, 32'd0, 1'b1);

    // Flush mid-CALC after a divide-by-zero result: no valid, q/r held, dbz cleared by start
    issue(32'd12345, 32'd11, 1'b0, n);
    void'(sb.pop_back());
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_valid", {31'b0, valid}, 32'd0);
    chk("flush_q", q, last_q);
    chk("flush_r", r, last_r);
    chk("flush_dbz", {31'b0, div_by_zero}, 32'd0);
    repeat (40) @(posedge clk);
    #1;

    // start together with flush in idle: nothing accepted
    @(negedge clk);
    start = 1'b1; flush = 1'b1; a = 32'd50; b = 32'd3; signed_op = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    chk("sflush_busy", {31'b0, busy}, 32'd0);
    repeat (40) @(posedge clk);
    #1;

    // Starts while busy are ignored
    issue(32'd1000, 32'd3, 1'b0, n);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; a = 32'd77; b = 32'd5; signed_op = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (26) @(posedge clk);
    @(negedge clk);
    start = 1'b1; a = 32'hFFFF_0000; b = 32'd9; signed_op = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("ign_valid", {31'b0, valid}, 32'd1);
    @(posedge clk);
    #1;
    chk("ign_requeue_busy", {31'b0, busy}, 32'd0);
    chk("ign_requeue_valid", {31'b0, valid}, 32'd0);
    run(32'd81, 32'd9, 1'b0);

    // Asynchronous reset in the middle of CALC
    issue(32'hDEAD_BEEF, 32'd13, 1'b0, n);
    void'(sb.pop_back());
    repeat (19) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_valid", {31'b0, valid}, 32'd0);
    chk("arst_q", q, 32'd0);
    chk("arst_r", r, 32'd0);
    chk("arst_dbz", {31'b0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    // Randomised operations
    for (int i = 0; i < 40; i++) begin
      int sel;
      ra  = $urandom;
      rs  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = '0;
      else if (sel == 1) rb = 32'($urandom_range(1, 5));
      else if (sel == 2) rb = 32'hFFFF_FFFF;
      else if (sel == 3) rb = -32'($urandom_range(1, 300));
      else rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      run(ra, rb, rs);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
